// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - VGA sink-side timing decoder; optional err_count via DECODER_ERRCNT_EN
module vga_timing_decoder #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       pix_ce,
   input  logic       hs,
   input  logic       vs,
   input  logic       blank_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pixel_valid,
   output logic       frame_start,
   output logic       locked,
   output logic       timing_error
`ifdef DECODER_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [10:0] H_TOTAL_L  = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_L  = 11'(V_TOTAL);
   localparam logic [10:0] H_ACTIVE_L = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACTIVE_L = 11'(V_ACTIVE);
   localparam logic [4:0]  LOCK_L     = 5'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [3:0]  good_q, good_d;
   logic        frame_bad_q, frame_bad_d;

   logic        hs_prev_q, hs_prev_d;
   logic        vs_prev_q, vs_prev_d;
   logic        hs_seen_q, hs_seen_d;
   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic [10:0] acnt_q, acnt_d;
   logic [9:0]  arows_q, arows_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        y_first_q, y_first_d;
   logic        pixel_valid_q, pixel_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        locked_q, locked_d;
   logic        timing_error_q, timing_error_d;

   logic        hs_fall, vs_fall;
   logic [10:0] acnt_line, line_len, vcnt_eff, arows_eff;
   logic        line_bad, frame_bad, violation;
   logic [4:0]  good_inc;
   logic        active_ok, y_first_now;

   // Edge detection, line/frame judgement and the free-running counters
   always_comb begin
      hs_fall   = pix_ce & hs_prev_q & ~hs;
      vs_fall   = pix_ce & vs_prev_q & ~vs;
      // The HS falling-edge sample belongs to the new line, so it sees an empty active count
      acnt_line = hs_fall ? 11'd0 : acnt_q;
      line_len  = {1'b0, hcnt_q} + 11'd1;
      line_bad  = (hs_fall & hs_seen_q &
                   ((line_len != H_TOTAL_L) | ((acnt_q != 11'd0) & (acnt_q != H_ACTIVE_L))))
                | (pix_ce & blank_n & (acnt_line == H_ACTIVE_L));
      // The line closing on this sample is folded into the frame totals before judging
      vcnt_eff  = {1'b0, vcnt_q} + {10'd0, hs_fall};
      arows_eff = {1'b0, arows_q} + {10'd0, hs_fall & (acnt_q != 11'd0)};
      frame_bad = vs_fall & (frame_bad_q | line_bad |
                             (vcnt_eff != V_TOTAL_L) | (arows_eff != V_ACTIVE_L));
      violation = line_bad | frame_bad;

      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      hs_seen_d = hs_seen_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      acnt_d    = acnt_q;
      arows_d   = arows_q;
      if (pix_ce) begin
         hs_prev_d = hs;
         vs_prev_d = vs;
         hs_seen_d = hs_seen_q | hs_fall;
         if (hs_fall)
            hcnt_d = 10'd0;
         else if (hcnt_q != 10'h3ff)
            hcnt_d = hcnt_q + 10'd1;
         if (vs_fall)
            vcnt_d = 10'd0;
         else if (hs_fall && (vcnt_q != 10'h3ff))
            vcnt_d = vcnt_q + 10'd1;
         acnt_d = acnt_line;
         if (blank_n && (acnt_line != 11'h7ff))
            acnt_d = acnt_line + 11'd1;
         if (vs_fall)
            arows_d = 10'd0;
         else if (hs_fall && (acnt_q != 11'd0) && (arows_q != 10'h3ff))
            arows_d = arows_q + 10'd1;
      end
   end

   // Lock state machine: next state
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      frame_bad_d = frame_bad_q;
      good_inc    = {1'b0, good_q} + 5'd1;
      case (state_q)
         SEARCH: begin
            if (vs_fall) begin
               state_d     = ACQUIRE;
               good_d      = 4'd0;
               frame_bad_d = 1'b0;
            end
         end
         ACQUIRE: begin
            if (vs_fall) begin
               frame_bad_d = 1'b0;
               if (frame_bad) begin
                  good_d = 4'd0;
               end else if (good_inc >= LOCK_L) begin
                  state_d = LOCKED;
                  good_d  = 4'd0;
               end else begin
                  good_d = good_inc[3:0];
               end
            end else if (line_bad) begin
               frame_bad_d = 1'b1;
            end
         end
         LOCKED: begin
            if (violation) begin
               state_d     = ACQUIRE;
               good_d      = 4'd0;
               // A violation mid-frame spoils the frame in progress; one at VS already closed it
               frame_bad_d = ~vs_fall;
            end
         end
         default: begin
            state_d     = SEARCH;
            good_d      = 4'd0;
            frame_bad_d = 1'b0;
         end
      endcase
   end

   // Outputs: pulses, lock level and active-pixel coordinates
   always_comb begin
      timing_error_d = (state_q == LOCKED) & violation;
      locked_d       = (state_d == LOCKED);
      frame_start_d  = vs_fall;
      active_ok      = (state_q == LOCKED) & pix_ce & blank_n & ~violation;
      pixel_valid_d  = active_ok;
      y_first_now    = y_first_q | vs_fall;
      y_first_d      = y_first_now;
      x_d            = x_q;
      y_d            = y_q;
      if (active_ok) begin
         if (acnt_line == 11'd0) begin
            x_d = 10'd0;
            if (y_first_now) begin
               y_d       = 10'd0;
               y_first_d = 1'b0;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   // Lock state register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= SEARCH;
         good_q      <= 4'd0;
         frame_bad_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         frame_bad_q <= frame_bad_d;
      end
   end

   // Counter and output registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hs_prev_q      <= 1'b1;
         vs_prev_q      <= 1'b1;
         hs_seen_q      <= 1'b0;
         hcnt_q         <= 10'd0;
         vcnt_q         <= 10'd0;
         acnt_q         <= 11'd0;
         arows_q        <= 10'd0;
         x_q            <= 10'd0;
         y_q            <= 10'd0;
         y_first_q      <= 1'b0;
         pixel_valid_q  <= 1'b0;
         frame_start_q  <= 1'b0;
         locked_q       <= 1'b0;
         timing_error_q <= 1'b0;
      end else begin
         hs_prev_q      <= hs_prev_d;
         vs_prev_q      <= vs_prev_d;
         hs_seen_q      <= hs_seen_d;
         hcnt_q         <= hcnt_d;
         vcnt_q         <= vcnt_d;
         acnt_q         <= acnt_d;
         arows_q        <= arows_d;
         x_q            <= x_d;
         y_q            <= y_d;
         y_first_q      <= y_first_d;
         pixel_valid_q  <= pixel_valid_d;
         frame_start_q  <= frame_start_d;
         locked_q       <= locked_d;
         timing_error_q <= timing_error_d;
      end
   end

`ifdef DECODER_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   // Saturating count of timing_error pulses
   always_comb begin
      err_count_d = err_count_q;
      if (timing_error_d && (err_count_q != 8'hff))
         err_count_d = err_count_q + 8'd1;
   end

   // Error counter register, cleared only by reset
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         err_count_q <= 8'd0;
      else
         err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`endif

   assign x            = x_q;
   assign y            = y_q;
   assign pixel_valid  = pixel_valid_q;
   assign frame_start  = frame_start_q;
   assign locked       = locked_q;
   assign timing_error = timing_error_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb/tb_vga_timing_decoder.sv - scoreboard testbench for vga_timing_decoder on a reduced raster
module tb_vga_timing_decoder;

   localparam int HT = 12, HA = 6, VT = 7, VA = 4, LF = 2;
   localparam int HS_W = 2, H_AS = 3, VS_W = 2, V_AS = 2;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       pix_ce = 1'b0;
   logic       hs = 1'b1;
   logic       vs = 1'b1;
   logic       blank_n = 1'b0;
   logic [9:0] x, y;
   logic       pixel_valid, frame_start, locked, timing_error;
`ifdef DECODER_ERRCNT_EN
   logic [7:0] err_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit pv;
      int ex;
      int ey;
      bit fs;
      bit te;
      bit lk;
   } exp_t;

   exp_t sb[$];
   bit   cur_lk = 1'b0;
   bit   fast = 1'b0;
   int   pv_seen, first_x, first_y, last_x, last_y;

   always #5 Clk = ~Clk;

   vga_timing_decoder #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce), .hs(hs), .vs(vs), .blank_n(blank_n),
      .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start),
      .locked(locked), .timing_error(timing_error)
`ifdef DECODER_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // One pixel strobe: push the expectation, drive, pop and compare after the edge
   task automatic tick(input bit h_s, input bit v_s, input bit b_n, input bit e_pv,
                       input int ex, input int ey, input bit e_fs, input bit e_te);
      exp_t e, g;
      e.pv = e_pv; e.ex = ex; e.ey = ey; e.fs = e_fs; e.te = e_te; e.lk = cur_lk;
      sb.push_back(e);
      hs = h_s; vs = v_s; blank_n = b_n; pix_ce = 1'b1;
      @(negedge Clk);
      g = sb.pop_front();
      checks++;
      if (pixel_valid !== g.pv) begin
         errors++;
         $display("FAIL pixel_valid: got %b want %b (x=%0d y=%0d)", pixel_valid, g.pv, g.ex, g.ey);
      end
      if (g.pv) begin
         checks++;
         if (x !== 10'(g.ex) || y !== 10'(g.ey)) begin
            errors++;
            $display("FAIL coord: got x=%0d y=%0d want x=%0d y=%0d", x, y, g.ex, g.ey);
         end
      end
      checks++;
      if (frame_start !== g.fs) begin
         errors++;
         $display("FAIL frame_start: got %b want %b", frame_start, g.fs);
      end
      checks++;
      if (timing_error !== g.te) begin
         errors++;
         $display("FAIL timing_error: got %b want %b", timing_error, g.te);
      end
      checks++;
      if (locked !== g.lk) begin
         errors++;
         $display("FAIL locked: got %b want %b", locked, g.lk);
      end
      if (pixel_valid === 1'b1) begin
         if (pv_seen == 0) begin
            first_x = int'(x);
            first_y = int'(y);
         end
         last_x = int'(x);
         last_y = int'(y);
         pv_seen++;
      end
      if (!fast) begin
         pix_ce = 1'b0;
         @(negedge Clk);
         checks++;
         if (pixel_valid !== 1'b0 || frame_start !== 1'b0 || timing_error !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got pv=%b fs=%b te=%b want all 0",
                     pixel_valid, frame_start, timing_error);
         end
      end
   endtask

   // Hold pix_ce low for 1000 Clk and require the outputs to stand still
   task automatic stall();
      logic [9:0] x0, y0;
      logic       l0;
      bit         changed;
      x0 = x; y0 = y; l0 = locked; changed = 1'b0;
      checks++;
      if (x0 !== 10'd1) begin
         errors++;
         $display("FAIL stall_entry_x: got %0d want 1", x0);
      end
      repeat (1000) begin
         @(negedge Clk);
         if (pixel_valid !== 1'b0 || frame_start !== 1'b0 || timing_error !== 1'b0 ||
             x !== x0 || y !== y0 || locked !== l0)
            changed = 1'b1;
      end
      checks++;
      if (changed) begin
         errors++;
         $display("FAIL stall_hold: got change=1 want 0");
      end
   endtask

   // One frame of the reduced raster; lk is the expected lock level from its VS edge on
   task automatic send_frame(input bit lk, input int short_line, input int extra_line,
                             input int stall_line, input int n_lines);
      int len;
      bit b, te;
      for (int v = 0; v < n_lines; v++) begin
         len = (v == short_line) ? HT - 1 : HT;
         for (int h = 0; h < len; h++) begin
            b  = (v >= V_AS && v < V_AS + VA && h >= H_AS && h < H_AS + HA) ||
                 (v == extra_line && h == H_AS + HA);
            te = 1'b0;
            if (v == 0 && h == 0)
               cur_lk = lk;
            if ((v == extra_line && h == H_AS + HA) ||
                (short_line >= 0 && v == short_line + 1 && h == 0)) begin
               te = cur_lk;
               cur_lk = 1'b0;
            end
            if (v == stall_line && h == H_AS + 2)
               stall();
            tick(h >= HS_W, v >= VS_W, b, b && cur_lk, h - H_AS, v - V_AS, v == 0 && h == 0, te);
         end
      end
   endtask

   task automatic check_frame_pixels(input string tag);
      checks++;
      if (pv_seen != HA * VA || first_x != 0 || first_y != 0 ||
          last_x != HA - 1 || last_y != VA - 1) begin
         errors++;
         $display("FAIL %s: got n=%0d first=(%0d,%0d) last=(%0d,%0d) want n=%0d first=(0,0) last=(%0d,%0d)",
                  tag, pv_seen, first_x, first_y, last_x, last_y, HA * VA, HA - 1, VA - 1);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clk);
      checks++;
      if (x !== 10'd0 || y !== 10'd0 || pixel_valid !== 1'b0 || frame_start !== 1'b0 ||
          locked !== 1'b0 || timing_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got x=%0d y=%0d pv=%b fs=%b lk=%b te=%b want all 0",
                  x, y, pixel_valid, frame_start, locked, timing_error);
      end
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_lock();
      send_frame(1'b0, -1, -1, -1, VT);
      send_frame(1'b0, -1, -1, -1, VT);
      pv_seen = 0;
      send_frame(1'b1, -1, -1, -1, VT);
      check_frame_pixels("lock_frame3");
      pv_seen = 0;
      send_frame(1'b1, -1, -1, -1, VT);
      check_frame_pixels("lock_frame4");
   endtask

   task automatic test_short_line();
      send_frame(1'b1, 3, -1, -1, VT);
      send_frame(1'b0, -1, -1, -1, VT);
      send_frame(1'b0, -1, -1, -1, VT);
      pv_seen = 0;
      send_frame(1'b1, -1, -1, -1, VT);
      check_frame_pixels("relock_after_short");
   endtask

   task automatic test_over_active();
      send_frame(1'b1, -1, 4, -1, VT);
      send_frame(1'b0, -1, -1, -1, VT);
      send_frame(1'b0, -1, -1, -1, VT);
      pv_seen = 0;
      send_frame(1'b1, -1, -1, -1, VT);
      check_frame_pixels("relock_after_over");
   endtask

   task automatic test_ce_stall();
      pv_seen = 0;
      send_frame(1'b1, -1, -1, 3, VT);
      check_frame_pixels("stall_frame");
   endtask

   task automatic test_async_reset();
      send_frame(1'b1, -1, -1, -1, 3);
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if (x !== 10'd0 || y !== 10'd0 || pixel_valid !== 1'b0 || frame_start !== 1'b0 ||
          locked !== 1'b0 || timing_error !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got x=%0d y=%0d pv=%b fs=%b lk=%b te=%b want all 0",
                  x, y, pixel_valid, frame_start, locked, timing_error);
      end
`ifdef DECODER_ERRCNT_EN
      checks++;
      if (err_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_errcnt: got %0d want 0", err_count);
      end
`endif
      @(negedge Clk);
      Reset_n = 1'b1;
      pix_ce = 1'b0;
      cur_lk = 1'b0;
      send_frame(1'b0, -1, -1, -1, VT);
      send_frame(1'b0, -1, -1, -1, VT);
      pv_seen = 0;
      send_frame(1'b1, -1, -1, -1, VT);
      check_frame_pixels("relock_after_reset");
   endtask

`ifdef DECODER_ERRCNT_EN
   task automatic test_err_count();
      fast = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send_frame(1'b1, 3, -1, -1, VT);
         send_frame(1'b0, -1, -1, -1, VT);
         send_frame(1'b0, -1, -1, -1, VT);
         if (i == 99 || i == 254 || i == 299) begin
            checks++;
            if (err_count !== ((i >= 254) ? 8'd255 : 8'(i + 1))) begin
               errors++;
               $display("FAIL err_count_%0d: got %0d want %0d", i + 1, err_count,
                        (i >= 254) ? 255 : i + 1);
            end
         end
      end
      send_frame(1'b1, -1, -1, -1, VT);
      fast = 1'b0;
      pix_ce = 1'b0;
      @(negedge Clk);
   endtask
`endif

   initial begin
      test_reset();
      test_lock();
      test_short_line();
      test_over_active();
      test_ce_stall();
      test_async_reset();
`ifdef DECODER_ERRCNT_EN
      test_err_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Sink-side counterpart to the VGA sync generator.
- Samples HS/VS/BLANK_N on pixel strobes, reconstructs active-pixel coordinates, checks timing against 640x480@60 parameters, and reports lock and errors.
- Sits on the video output path for on-board self-check, and as a capture front-end for a frame grabber/monitor in the bench.

Parameters:
- H_TOTAL, 800, pixel strobes per line (HS falling edge to HS falling edge).
- V_TOTAL, 525, lines per frame (VS falling edge to VS falling edge).
- H_ACTIVE, 640, active (BLANK_N=1) samples required per line inside the active region.
- V_ACTIVE, 480, lines per frame that must contain active samples.
- LOCK_FRAMES, 2, consecutive good frames needed to reach LOCKED (1..15).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_ce  in  1  one-Clk strobe per pixel; all sampling and counting happens only when pix_ce=1.
- hs  in  1  horizontal sync, active-low.
- vs  in  1  vertical sync, active-low.
- blank_n  in  1  1 = active video pixel.
- x  out  10  active column of the last valid pixel.
- y  out  10  active row of the last valid pixel.
- pixel_valid  out  1  one-Clk pulse; x/y describe an active pixel while locked.
- frame_start  out  1  one-Clk pulse on a VS falling edge.
- locked  out  1  level; timing verified.
- timing_error  out  1  one-Clk pulse on a detected violation.
- err_count  out  8  saturating error count; present only with DECODER_ERRCNT_EN.

Behaviour:
- Reset (async, Reset_n=0): all outputs 0; state = SEARCH; all counters 0; hs_prev/vs_prev = 1; hs_seen = 0.
- Edge detection is done only on pix_ce cycles, against the values registered at the previous pix_ce.
- hcnt (10b, saturates at 1023):
  - Cleared to 0 on the HS falling-edge sample.
  - Otherwise increments each pix_ce.
  - Line length = hcnt+1, evaluated at the next HS falling edge. Only checked when hs_seen=1.
- vcnt (10b, saturates at 1023):
  - Cleared on a VS falling edge.
  - Incremented on each HS falling edge.
- acnt (11b): counts blank_n=1 samples in the current line. Cleared on the HS falling edge after it is evaluated.
- arows: counts lines with acnt>0.
- Line bad if any of:
  - line length != H_TOTAL;
  - acnt not in {0, H_ACTIVE};
  - a blank_n=1 sample with acnt already = H_ACTIVE (checked immediately).
- Frame bad if, at the VS falling edge, either holds:
  - vcnt != V_TOTAL;
  - arows != V_ACTIVE.
  - The current line is evaluated first when HS and VS fall on the same sample.
- State machine:
  - SEARCH: on a VS falling edge, go to ACQUIRE with good=0. The partial first frame is never judged.
  - ACQUIRE: a bad line marks the frame bad. At the VS falling edge:
    - good frame: good+1;
    - bad frame: good=0;
    - when good reaches LOCK_FRAMES: go to LOCKED, locked=1 from the next Clk.
  - LOCKED: the first bad line or bad frame drives timing_error=1 for one Clk, locked=0, good=0, state = ACQUIRE. No return to SEARCH.
  - timing_error pulses only in LOCKED, at most once per violation sample.
- Coordinates, updated only while locked:
  - First blank_n=1 sample of a line: x=0.
  - Later active samples: x+1.
  - y=0 on the first active line after a VS falling edge; +1 on the first active sample of each later line.
  - pixel_valid=1 on the Clk after each active pix_ce sample. Latency = 1 Clk.
  - frame_start is registered the same way, in any state.
- Locked flag is cleared on the same Clk that sees the violation, so the violating sample produces no pixel_valid.
- pix_ce held low: no state, counter or output change. Pulses return to 0 after one Clk.

Optional Feature:
- Macro: DECODER_ERRCNT_EN.
  - Defined: err_count port exists; +1 per timing_error pulse, saturating at 255; cleared only by reset.
  - Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert Reset_n=0 mid-stream asynchronously -> all outputs 0 within the same Clk; state SEARCH.
- Ideal 640x480 stream with pix_ce every 2nd Clk:
  - locked=1 after the 3rd VS falling edge;
  - next frame: first pixel_valid has x=0,y=0; last has x=639,y=479;
  - exactly 307200 pixel_valid pulses per frame.
- Locked, one line shortened to 799 strobes -> one timing_error pulse at that line's closing HS edge; locked=0; re-locks after 2 further good frames.
- Locked, a line with 641 active samples -> timing_error on the 641st sample; no pixel_valid for it.
- pix_ce held 0 for 1000 Clk mid-line -> no output change; stream resumes with correct x continuity.
- With DECODER_ERRCNT_EN: 300 injected violations -> err_count = 255 and stays there.
